// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit timing, arbiter state encoding and
// a sizing helper used by the transmit-side blocks.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 10416;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } tx_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of valid_i at or above ptr_i,
// wrapping around. Returns one-hot grant, its index and an any-valid flag.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  localparam logic [PW:0] NQ = N_REQ[PW:0];

  logic [N_REQ-1:0] rot;
  logic [PW-1:0]    off;
  logic [PW:0]      sum;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr_i; the lowest set bit wins.
    rot   = N_REQ'({valid_i, valid_i} >> ptr_i);
    off   = '0;
    any_o = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off   = k[PW-1:0];
        any_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NQ) sum = sum - NQ;
    idx_o          = sum[PW-1:0];
    grant_o        = '0;
    grant_o[idx_o] = any_o;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART byte transmitter: issues one
// start per byte, waits for the busy handshake, then inserts an idle gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int GAP_BITS     = 2,
  parameter int ACK_CYCLES   = 16,
  parameter int STALL_CYCLES = 104160
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_busy_i,
  output logic                 err_o,
  output logic                 active_o
);

  localparam int PW      = $clog2(N_REQ);
  localparam int GAP_CYC = (GAP_BITS * CLKS_PER_BIT == 0) ? 1 : GAP_BITS * CLKS_PER_BIT;
  localparam int MAXC    = max3(STALL_CYCLES, ACK_CYCLES, GAP_CYC);
  localparam int CW      = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] STALL_LIM = CW'(STALL_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LIM   = CW'(ACK_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LIM   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAXC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [PW:0]   NQ        = N_REQ[PW:0];
  localparam logic [PW:0]   G_ONE     = (PW+1)'(1);

  tx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    g_q, g_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [7:0]       txd_q, txd_d;
  logic             last_q, last_d;
  logic             start_q, start_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic             g_valid;
  logic [PW:0]      g_inc;
  logic [PW-1:0]    rr_next;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (rr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign g_valid = req_valid_i[g_q];
  assign g_inc   = {1'b0, g_q} + G_ONE;
  assign rr_next = (g_inc == NQ) ? '0 : g_inc[PW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (arb_any) state_d = ST_SEND;
      ST_SEND: begin
        if (g_valid)                 state_d = ST_WAIT_ACK;
        else if (cnt_q == STALL_LIM) state_d = ST_GAP;
      end
      // Busy wins over the timeout when both land on the same cycle.
      ST_WAIT_ACK: begin
        if (tx_busy_i)             state_d = ST_WAIT_DONE;
        else if (cnt_q == ACK_LIM) state_d = ST_GAP;
      end
      ST_WAIT_DONE: if (!tx_busy_i) state_d = last_q ? ST_GAP : ST_SEND;
      ST_GAP:       if (cnt_q == GAP_LIM) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    g_d     = g_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    txd_d   = txd_q;
    last_d  = last_q;
    ready_d = '0;
    start_d = 1'b0;
    err_d   = 1'b0;
    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q == CNT_MAX)  cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CNT_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          g_d     = arb_idx;
          grant_d = arb_grant;
        end
      end
      ST_SEND: begin
        if (g_valid) begin
          txd_d   = req_data_i[{g_q, 3'b000} +: 8];
          last_d  = req_last_i[g_q];
          start_d = 1'b1;
          ready_d = grant_q;
        end else if (cnt_q == STALL_LIM) begin
          err_d   = 1'b1;
          grant_d = '0;
          rr_d    = rr_next;
        end
      end
      ST_WAIT_ACK: begin
        if (!tx_busy_i && cnt_q == ACK_LIM) begin
          err_d   = 1'b1;
          grant_d = '0;
          rr_d    = rr_next;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i && last_q) begin
          grant_d = '0;
          rr_d    = rr_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      g_q     <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      ready_q <= '0;
      txd_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      txd_q   <= txd_d;
      last_q  <= last_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign grant_o     = grant_q;
  assign tx_data_o   = txd_q;
  assign tx_start_o  = start_q;
  assign err_o       = err_q;
  assign active_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-producer and transmitter models, a scoreboard
// of expected (requester, byte) starts, an arbitration table and corner sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready_o;
  logic [3:0]  grant_o;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_busy;
  logic        err_o;
  logic        active_o;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4), .CLKS_PER_BIT(4), .GAP_BITS(2), .ACK_CYCLES(4), .STALL_CYCLES(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .tx_data_o   (tx_data_o),
    .tx_start_o  (tx_start_o),
    .tx_busy_i   (tx_busy),
    .err_o       (err_o),
    .active_o    (active_o)
  );

  typedef struct { logic [7:0] d; logic l; } byte_t;
  typedef struct { int g; logic [7:0] d; } exp_t;
  typedef struct { logic [3:0] mask; int exp_g; } vec_t;

  byte_t pq [4][$];
  exp_t  sb [$];

  int total = 0, bad = 0;
  int cyc = 0, n_start = 0, n_err = 0, last_g = -1, rep = 0;
  int busy_len = 6, rem = 0, fall_cyc = 0;
  bit stuck = 1'b0;

  function automatic logic [3:0] oh(input int g);
    logic [3:0] one;
    one = 4'd1;
    return one << g;
  endfunction

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]        = (pq[i].size() != 0);
      req_data[8*i +: 8]  = (pq[i].size() != 0) ? pq[i][0].d : 8'h00;
      req_last[i]         = (pq[i].size() != 0) ? pq[i][0].l : 1'b0;
    end
  endtask

  // One clock: sample just after the edge, run monitors and models, re-drive.
  task automatic step();
    exp_t e;
    int   g;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (tx_start_o) begin
        n_start++;
        g = idx_of(grant_o);
        if (n_start > 1 && g == last_g) rep++;
        last_g = g;
        if (sb.size() == 0) fail_now("unexpected_tx_start");
        else begin
          e = sb.pop_front();
          chk("tx_data", {24'h0, tx_data_o}, {24'h0, e.d});
          chk("tx_grant", {28'h0, grant_o}, {28'h0, oh(e.g)});
        end
        chk("ready_with_start", {28'h0, req_ready_o}, {28'h0, grant_o});
      end
      if ((req_ready_o & ~grant_o) != 4'h0) fail_now("ready_to_non_granted");
      if (err_o) n_err++;
      for (int i = 0; i < 4; i++)
        if (req_ready_o[i] && pq[i].size() != 0) void'(pq[i].pop_front());
      if (tx_start_o && !stuck) begin
        tx_busy = 1'b1;
        rem     = busy_len;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          tx_busy  = 1'b0;
          fall_cyc = cyc;
        end
      end
    end
    drive();
  endtask

  task automatic wait_starts(input int n, input int bound);
    int k = 0;
    while (n_start < n && k < bound) begin step(); k++; end
    if (n_start < n) fail_now("start_timeout");
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (active_o && k < bound) begin step(); k++; end
    if (active_o) fail_now("idle_timeout");
  endtask

  task automatic wait_err(input int e0, input int bound);
    int k = 0;
    while (n_err == e0 && k < bound) begin step(); k++; end
    if (n_err == e0) fail_now("err_timeout");
  endtask

  task automatic clear_models();
    for (int i = 0; i < 4; i++) pq[i].delete();
    sb.delete();
    tx_busy = 1'b0;
    rem     = 0;
    n_start = 0;
    last_g  = -1;
    rep     = 0;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    clear_models();
    drive();
    step();
    step();
    #3 rst_n = 1'b1;
  endtask

  task automatic push(input int g, input logic [7:0] d, input logic l, input bit exp_now);
    pq[g].push_back('{d: d, l: l});
    if (exp_now) sb.push_back('{g: g, d: d});
  endtask

  vec_t vt [8];

  initial begin
    int c0, n, e0, ts;
    // Starting from rr_ptr=0 each record's winner moves the pointer to winner+1.
    vt[0] = '{4'b0001, 0};
    vt[1] = '{4'b0001, 0};
    vt[2] = '{4'b1111, 1};
    vt[3] = '{4'b1001, 3};
    vt[4] = '{4'b0110, 1};
    vt[5] = '{4'b0100, 2};
    vt[6] = '{4'b0011, 0};
    vt[7] = '{4'b1000, 3};

    rst_n = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    clear_models();
    step(); step();
    chk("rst_grant", {28'h0, grant_o}, 32'h0);
    chk("rst_ready", {28'h0, req_ready_o}, 32'h0);
    chk("rst_start", {31'h0, tx_start_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_active", {31'h0, active_o}, 32'h0);
    chk("rst_txdata", {24'h0, tx_data_o}, 32'h0);
    #3 rst_n = 1'b1;
    step();

    // Single two-byte packet, long frames.
    busy_len = 40;
    push(0, 8'hA5, 1'b0, 1'b1);
    push(0, 8'h5A, 1'b1, 1'b1);
    drive();
    c0 = cyc;
    wait_starts(1, 20);
    chk("first_byte_latency", cyc - c0, 2);
    wait_starts(2, 200);
    n = 0;
    while (grant_o != 4'h0 && n < 200) begin step(); n++; end
    n = 0;
    while (active_o && n < 50) begin step(); n++; end
    chk("gap_cycles", n, 8);
    chk("single_starts", n_start, 2);
    chk("single_sb_empty", sb.size(), 0);

    // Round robin with every source held valid.
    do_reset();
    busy_len = 6;
    push(0, 8'h11, 1'b1, 1'b0); push(0, 8'h15, 1'b1, 1'b0);
    push(1, 8'h12, 1'b1, 1'b0); push(2, 8'h13, 1'b1, 1'b0); push(3, 8'h14, 1'b1, 1'b0);
    sb.push_back('{0, 8'h11}); sb.push_back('{1, 8'h12}); sb.push_back('{2, 8'h13});
    sb.push_back('{3, 8'h14}); sb.push_back('{0, 8'h15});
    drive();
    wait_starts(5, 400);
    wait_idle(100);
    chk("rr_repeats", rep, 0);
    chk("rr_sb_empty", sb.size(), 0);

    // Arbitration table: one-byte packets from each masked source.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++)
        if (vt[r].mask[i]) push(i, 8'(r * 16 + i), 1'b1, 1'b0);
      sb.push_back('{vt[r].exp_g, 8'(r * 16 + vt[r].exp_g)});
      n_start = 0;
      drive();
      wait_starts(1, 50);
      for (int i = 0; i < 4; i++) pq[i].delete();
      drive();
      wait_idle(100);
    end
    chk("table_sb_empty", sb.size(), 0);

    // Packet lock: req0 arrives while req1 is mid-packet.
    n_start = 0;
    push(1, 8'hB1, 1'b0, 1'b1); push(1, 8'hB2, 1'b0, 1'b1); push(1, 8'hB3, 1'b1, 1'b1);
    drive();
    wait_starts(1, 50);
    push(0, 8'hC0, 1'b1, 1'b1);
    drive();
    wait_starts(4, 600);
    wait_idle(100);
    chk("lock_sb_empty", sb.size(), 0);

    // Ack timeout: transmitter never asserts busy for req2's byte.
    n_start = 0;
    stuck = 1'b1;
    push(2, 8'h77, 1'b1, 1'b1);
    push(3, 8'h88, 1'b1, 1'b1);
    e0 = n_err;
    drive();
    wait_starts(1, 50);
    ts = cyc;
    wait_err(e0, 20);
    chk("ack_err_delay", cyc - ts, 4);
    stuck = 1'b0;
    step();
    chk("ack_err_width", {31'h0, err_o}, 32'h0);
    wait_starts(2, 100);
    wait_idle(100);
    chk("ack_err_count", n_err - e0, 1);

    // Stall abort: req2 sends a non-last byte, then drops valid.
    n_start = 0;
    busy_len = 6;
    push(2, 8'h42, 1'b0, 1'b1);
    e0 = n_err;
    drive();
    wait_starts(1, 50);
    wait_err(e0, 60);
    // Busy fall exits WAIT_DONE on the next edge, then 8 stalled cycles in SEND.
    chk("stall_err_delay", cyc - fall_cyc, 9);
    chk("stall_grant_released", {28'h0, grant_o}, 32'h0);
    wait_idle(100);
    push(0, 8'h50, 1'b1, 1'b0);
    push(3, 8'h53, 1'b1, 1'b0);
    sb.push_back('{3, 8'h53});
    sb.push_back('{0, 8'h50});
    drive();
    wait_starts(3, 200);
    wait_idle(100);
    chk("stall_sb_empty", sb.size(), 0);

    // Async reset while WAIT_DONE, after moving rr_ptr away from 0.
    n_start = 0;
    busy_len = 30;
    push(1, 8'h61, 1'b1, 1'b1);
    drive();
    wait_starts(1, 50);
    wait_idle(100);
    push(2, 8'h62, 1'b0, 1'b1);
    push(2, 8'h63, 1'b1, 1'b0);
    drive();
    wait_starts(2, 50);
    step(); step(); step();
    e0 = n_err;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_grant", {28'h0, grant_o}, 32'h0);
    chk("arst_active", {31'h0, active_o}, 32'h0);
    chk("arst_txdata", {24'h0, tx_data_o}, 32'h0);
    chk("arst_ready_start_err", {29'h0, |req_ready_o, tx_start_o, err_o}, 32'h0);
    clear_models();
    drive();
    step(); step();
    #3 rst_n = 1'b1;
    push(0, 8'h70, 1'b1, 1'b0);
    push(2, 8'h72, 1'b1, 1'b0);
    sb.push_back('{0, 8'h70});
    sb.push_back('{2, 8'h72});
    busy_len = 6;
    drive();
    wait_starts(2, 200);
    wait_idle(100);
    chk("arst_no_err", n_err - e0, 0);
    chk("arst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
